// File: rtl/zorro_ac_pkg.sv
// Shared constants for the multi-board Zorro II autoconfig responder:
// size codes, register offsets (AL = address bits 6:1) and DTACK states.
package zorro_ac_pkg;

  localparam logic [2:0] SZ_2M = 3'b110;
  localparam logic [2:0] SZ_4M = 3'b111;
  localparam logic [2:0] SZ_8M = 3'b000;

  localparam logic [5:0] AC_TYPE   = 6'h00;
  localparam logic [5:0] AC_SIZE   = 6'h01;
  localparam logic [5:0] AC_PROD_H = 6'h02;
  localparam logic [5:0] AC_PROD_L = 6'h03;
  localparam logic [5:0] AC_FLAGS  = 6'h04;
  localparam logic [5:0] AC_MFG0   = 6'h08;
  localparam logic [5:0] AC_MFG1   = 6'h09;
  localparam logic [5:0] AC_MFG2   = 6'h0A;
  localparam logic [5:0] AC_MFG3   = 6'h0B;
  localparam logic [5:0] AC_CSR0   = 6'h20;
  localparam logic [5:0] AC_CSR1   = 6'h21;
  localparam logic [5:0] AC_BASE_H = 6'h24;
  localparam logic [5:0] AC_BASE_L = 6'h25;
  localparam logic [5:0] AC_SHUTUP = 6'h26;

  typedef enum logic [1:0] {
    DT_IDLE = 2'd0,
    DT_WAIT = 2'd1,
    DT_ACK  = 2'd2
  } dtack_state_e;

  // Which of AH[23:21] take part in the base compare for a given board size.
  function automatic logic [2:0] size_mask(input logic [2:0] code);
    logic [2:0] m;
    case (code)
      SZ_4M:   m = 3'b110;
      SZ_8M:   m = 3'b100;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/zorro_board_slot.sv
// One logical board: latched base address, configured/shut-up flags and
// the raw address match (priority between boards is resolved by the top).
module zorro_board_slot
  import zorro_ac_pkg::*;
#(
  parameter logic [2:0] SIZE_CODE = SZ_2M
) (
  input  logic       CLK,
  input  logic       _RST,
  input  logic       base_we,
  input  logic       shut_we,
  input  logic [2:0] base_in,
  input  logic [2:0] ah_hi,
  output logic       hit
);

  localparam logic [2:0] MASK = size_mask(SIZE_CODE);

  logic [2:0] base_q, base_d;
  logic       configured_q, configured_d;
  logic       shutup_q, shutup_d;

  always_comb begin
    base_d       = base_q;
    configured_d = configured_q;
    shutup_d     = shutup_q;
    if (base_we) begin
      base_d       = base_in;
      configured_d = 1'b1;
    end
    if (shut_we) shutup_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      base_q       <= 3'b000;
      configured_q <= 1'b0;
      shutup_q     <= 1'b0;
    end else begin
      base_q       <= base_d;
      configured_q <= configured_d;
      shutup_q     <= shutup_d;
    end
  end

  assign hit = configured_q & ~shutup_q & (((ah_hi ^ base_q) & MASK) == 3'b000);

endmodule

// File: rtl/zorro_autoconfig_multi.sv
// Zorro II autoconfig responder presenting NUM_BOARDS boards in turn at
// $E8xxxx, with synchronised strobes and a wait-state DTACK generator.
module zorro_autoconfig_multi
  import zorro_ac_pkg::*;
#(
  parameter int                        NUM_BOARDS  = 2,
  parameter logic [3*NUM_BOARDS-1:0]   SIZE_CODES  = {3'b110, 3'b110},
  parameter logic [8*NUM_BOARDS-1:0]   PRODUCT_IDS = {8'h31, 8'h30},
  parameter logic [15:0]               MFG_ID      = 16'h0A55,
  parameter int                        DTACK_WAIT  = 1
) (
  input  logic                  CLK,
  input  logic                  _RST,
  input  logic [7:0]            AH,
  input  logic [5:0]            AL,
  input  logic [3:0]            D_i,
  input  logic                  _AS,
  input  logic                  _UDS,
  input  logic                  RW,
  input  logic                  _configin,
  output logic                  _configout,
  output logic [3:0]            D_o,
  output logic                  config_oe,
  output logic                  DTACK,
  output logic [NUM_BOARDS-1:0] ce
);

  logic [1:0] as_sync_q, as_sync_d;
  logic [2:0] uds_sync_q, uds_sync_d;
  logic [2:0] cur_q, cur_d;
  logic       configout_q, configout_d;
  logic [2:0] cnt_q, cnt_d;
  dtack_state_e state_q, state_d;

  logic                  as_s, uds_fall, in_range, cfg_active;
  logic                  wr_ok, base_we, shut_we, taken;
  logic [2:0]            cur_size;
  logic [7:0]            cur_prod;
  logic [3:0]            rd_nib;
  logic [NUM_BOARDS-1:0] hit;
  logic                  unused_d0;

  assign unused_d0 = D_i[0];

  // Synchronisers; the third _UDS stage only exists for edge detection.
  assign as_sync_d  = {as_sync_q[0], _AS};
  assign uds_sync_d = {uds_sync_q[1:0], _UDS};
  assign as_s       = as_sync_q[1];
  assign uds_fall   = uds_sync_q[2] & ~uds_sync_q[1];

  assign in_range   = cur_q < 3'(NUM_BOARDS);
  assign cfg_active = (AH == 8'hE8) & ~_configin & in_range & ~as_s;

  always_comb begin
    cur_size = SIZE_CODES[2:0];
    cur_prod = PRODUCT_IDS[7:0];
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (cur_q == 3'(i)) begin
        cur_size = SIZE_CODES[3*i +: 3];
        cur_prod = PRODUCT_IDS[8*i +: 8];
      end
    end
  end

  always_comb begin
    case (AL)
      AC_TYPE:            rd_nib = 4'hE;
      AC_SIZE:            rd_nib = {1'b0, cur_size};
      AC_PROD_H:          rd_nib = cur_prod[7:4];
      AC_PROD_L:          rd_nib = cur_prod[3:0];
      AC_FLAGS:           rd_nib = 4'h7;
      AC_MFG0:            rd_nib = MFG_ID[15:12];
      AC_MFG1:            rd_nib = MFG_ID[11:8];
      AC_MFG2:            rd_nib = MFG_ID[7:4];
      AC_MFG3:            rd_nib = MFG_ID[3:0];
      AC_CSR0, AC_CSR1:   rd_nib = 4'h0;
      default:            rd_nib = 4'hF;
    endcase
  end

  assign config_oe = cfg_active & RW;
  assign D_o       = config_oe ? rd_nib : 4'hF;

  // Only the strobe edge acts, so a long-held _UDS advances the chain once.
  assign wr_ok   = uds_fall & cfg_active & ~RW;
  assign base_we = wr_ok & (AL == AC_BASE_H);
  assign shut_we = wr_ok & (AL == AC_SHUTUP);

  always_comb begin
    cur_d       = cur_q + {2'b00, base_we | shut_we};
    configout_d = (cur_q != 3'(NUM_BOARDS));
  end

  for (genvar i = 0; i < NUM_BOARDS; i++) begin : g_slot
    zorro_board_slot #(
      .SIZE_CODE(SIZE_CODES[3*i +: 3])
    ) u_slot (
      .CLK    (CLK),
      ._RST   (_RST),
      .base_we(base_we & (cur_q == 3'(i))),
      .shut_we(shut_we & (cur_q == 3'(i))),
      .base_in(D_i[3:1]),
      .ah_hi  (AH[7:5]),
      .hit    (hit[i])
    );
  end

  // Lowest-numbered matching board wins on overlap.
  always_comb begin
    ce    = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (hit[i] && !taken) begin
        ce[i] = ~as_s;
        taken = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (as_s) begin
      state_d = DT_IDLE;
    end else begin
      case (state_q)
        DT_IDLE:
          if (cfg_active || (|ce)) begin
            if (DTACK_WAIT == 0) begin
              state_d = DT_ACK;
            end else begin
              state_d = DT_WAIT;
              cnt_d   = 3'(DTACK_WAIT);
            end
          end
        DT_WAIT: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = DT_ACK;
        end
        DT_ACK:  state_d = DT_ACK;
        default: state_d = DT_IDLE;
      endcase
    end
  end

  assign DTACK      = (state_q == DT_ACK) & ~as_s;
  assign _configout = configout_q;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      as_sync_q   <= 2'b11;
      uds_sync_q  <= 3'b111;
      cur_q       <= 3'd0;
      configout_q <= 1'b1;
      cnt_q       <= 3'd0;
      state_q     <= DT_IDLE;
    end else begin
      as_sync_q   <= as_sync_d;
      uds_sync_q  <= uds_sync_d;
      cur_q       <= cur_d;
      configout_q <= configout_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_zorro_autoconfig_multi.sv
// Randomised bench for zorro_autoconfig_multi against an address-range model,
// plus fixed scenarios with hand-computed expectations.
module tb_zorro_autoconfig_multi;

  localparam int N = 2;
  localparam int W = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] ah = 8'h00;
  logic [5:0] al = 6'h00;
  logic [3:0] d_i = 4'h0;
  logic       as_n = 1'b1, uds_n = 1'b1, rw = 1'b1, cfgin_n = 1'b0;
  logic       cfgout_n, config_oe, dtack;
  logic [3:0] d_o;
  logic [N-1:0] ce;

  int checks = 0, failures = 0;

  // Board 0: 2MB, board 1: 4MB.
  zorro_autoconfig_multi #(
    .NUM_BOARDS(N), .SIZE_CODES(6'b111_110), .PRODUCT_IDS(16'h3130),
    .MFG_ID(16'h0A55), .DTACK_WAIT(W)
  ) dut (
    .CLK(clk), ._RST(rst_n), .AH(ah), .AL(al), .D_i(d_i), ._AS(as_n), ._UDS(uds_n),
    .RW(rw), ._configin(cfgin_n), ._configout(cfgout_n), .D_o(d_o),
    .config_oe(config_oe), .DTACK(dtack), .ce(ce)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit       a_hist [2];
  bit       u_hist [3];
  int       m_cur;
  bit       m_cfgd [N];
  logic [2:0] m_base [N];
  bit       m_cfgout, started, m_act, m_fall;
  int       run;
  logic [N-1:0] m_ce;

  function automatic logic [2:0] sz_of(input int i);
    return (i == 0) ? 3'b110 : 3'b111;
  endfunction

  function automatic logic [7:0] pid_of(input int i);
    return (i == 0) ? 8'h30 : 8'h31;
  endfunction

  function automatic int span_of(input logic [2:0] s);
    if (s == 3'b110) return 32'h200000;
    if (s == 3'b111) return 32'h400000;
    return 32'h800000;
  endfunction

  function automatic bit exp_act();
    return (ah == 8'hE8) && !cfgin_n && (m_cur < N) && !a_hist[1];
  endfunction

  function automatic logic [3:0] exp_dout();
    logic [3:0] v;
    if (!(exp_act() && rw)) return 4'hF;
    case (al)
      6'h00: v = 4'hE;
      6'h01: v = {1'b0, sz_of(m_cur)};
      6'h02: v = pid_of(m_cur) >> 4;
      6'h03: v = pid_of(m_cur) & 8'h0F;
      6'h04: v = 4'h7;
      6'h08: v = 4'h0;
      6'h09: v = 4'hA;
      6'h0A: v = 4'h5;
      6'h0B: v = 4'h5;
      6'h20, 6'h21: v = 4'h0;
      default: v = 4'hF;
    endcase
    return v;
  endfunction

  // A board covers the naturally aligned window of its size that holds base*2MB.
  function automatic logic [N-1:0] exp_ce();
    logic [N-1:0] r = '0;
    int addr, lo, span;
    bit found = 0;
    addr = int'(ah) << 16;
    for (int i = 0; i < N; i++) begin
      span = span_of(sz_of(i));
      lo = (int'(m_base[i]) << 21) & ~(span - 1);
      if (m_cfgd[i] && !a_hist[1] && addr >= lo && addr < lo + span && !found) begin
        r[i] = 1'b1;
        found = 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hist = '{1, 1};
      u_hist = '{1, 1, 1};
      m_cur = 0;
      m_cfgd = '{0, 0};
      m_base = '{3'd0, 3'd0};
      m_cfgout = 1;
      started = 0;
      run = 0;
    end else begin
      m_act  = exp_act();
      m_fall = u_hist[2] && !u_hist[1];
      m_ce   = exp_ce();
      m_cfgout = (m_cur != N);
      if (m_fall && m_act && !rw) begin
        if (al == 6'h24) begin
          m_base[m_cur] = d_i[3:1];
          m_cfgd[m_cur] = 1;
          m_cur++;
        end else if (al == 6'h26) begin
          m_cur++;
        end
      end
      if (a_hist[1]) begin
        started = 0;
        run = 0;
      end else if (started || m_act || m_ce != 0) begin
        started = 1;
        run++;
      end
      a_hist[1] = a_hist[0]; a_hist[0] = as_n;
      u_hist[2] = u_hist[1]; u_hist[1] = u_hist[0]; u_hist[0] = uds_n;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    chk("m_configout", {7'd0, cfgout_n}, {7'd0, m_cfgout});
    chk("m_d_o", {4'd0, d_o}, {4'd0, exp_dout()});
    chk("m_config_oe", {7'd0, config_oe}, {7'd0, exp_act() && rw});
    chk("m_dtack", {7'd0, dtack}, {7'd0, started && run >= W + 1 && !a_hist[1]});
    chk("m_ce", {6'd0, ce}, {6'd0, exp_ce()});
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic [23:0] addr, input logic rw_i, input logic [3:0] d);
    @(negedge clk);
    ah = addr[23:16]; al = addr[6:1]; rw = rw_i; d_i = d; as_n = 1'b0; uds_n = 1'b0;
  endtask

  task automatic stop(input int gap);
    as_n = 1'b1; uds_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic bus(input logic [23:0] addr, input logic rw_i, input logic [3:0] d,
                     input int hold, input int gap);
    start(addr, rw_i, d);
    repeat (hold) @(negedge clk);
    stop(gap);
  endtask

  task automatic rd_lit(input logic [23:0] addr, input logic [3:0] exp, input string nm);
    start(addr, 1'b1, 4'h0);
    repeat (4) @(negedge clk);
    chk(nm, {4'd0, d_o}, {4'd0, exp});
    chk({nm, "_oe"}, {7'd0, config_oe}, 8'd1);
    stop(3);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic [5:0] al_list [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0A, 6'h0B,
                               6'h20, 6'h21, 6'h24, 6'h24, 6'h24, 6'h25, 6'h26, 6'h3F};

  initial begin
    logic [23:0] a;
    #1 rst_n = 1'b0;
    #13 rst_n = 1'b1;
    #1;
    chk("rst_configout", {7'd0, cfgout_n}, 8'd1);
    chk("rst_dtack", {7'd0, dtack}, 8'd0);
    chk("rst_ce", {6'd0, ce}, 8'd0);
    chk("rst_oe", {7'd0, config_oe}, 8'd0);
    chk("rst_d_o", {4'd0, d_o}, 8'h0F);

    // DTACK latency: as_s low after 2 edges, DTACK after W+1 more.
    start(24'hE80002, 1'b1, 4'h0);
    repeat (3) @(negedge clk);
    chk("lat_before", {7'd0, dtack}, 8'd0);
    @(negedge clk);
    chk("lat_dtack", {7'd0, dtack}, 8'd1);
    chk("rd_size0", {4'd0, d_o}, 8'h06);
    stop(3);
    rd_lit(24'hE80000, 4'hE, "rd_type");

    bus(24'hE80048, 1'b0, 4'h2, 20, 3);
    rd_lit(24'hE80006, 4'h1, "rd_prod_l1");
    start(24'h200000, 1'b1, 4'h0);
    repeat (3) @(negedge clk);
    chk("ce_200000", {6'd0, ce}, 8'h01);
    stop(3);
    start(24'h400000, 1'b1, 4'h0);
    repeat (3) @(negedge clk);
    chk("ce_400000", {6'd0, ce}, 8'h00);
    stop(3);

    bus(24'hE8004C, 1'b0, 4'h0, 20, 3);
    chk("shut_configout", {7'd0, cfgout_n}, 8'd0);
    start(24'hE80000, 1'b1, 4'h0);
    repeat (4) @(negedge clk);
    chk("done_oe", {7'd0, config_oe}, 8'd0);
    chk("done_d_o", {4'd0, d_o}, 8'h0F);
    stop(3);

    // Reset in the middle of an acknowledged RAM access.
    start(24'h200000, 1'b1, 4'h0);
    repeat (4) @(negedge clk);
    chk("mid_dtack_pre", {7'd0, dtack}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_dtack", {7'd0, dtack}, 8'd0);
    chk("mid_ce", {6'd0, ce}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    stop(2);
    chk("mid_configout", {7'd0, cfgout_n}, 8'd1);
    rd_lit(24'hE80002, 4'h6, "rd_after_rst");

    // Overlap: both boards at base 010.
    bus(24'hE80048, 1'b0, 4'h4, 5, 3);
    bus(24'hE80048, 1'b0, 4'h4, 5, 3);
    start(24'h400000, 1'b1, 4'h0);
    repeat (3) @(negedge clk);
    chk("ovl_400000", {6'd0, ce}, 8'h01);
    stop(3);
    start(24'h600000, 1'b1, 4'h0);
    repeat (3) @(negedge clk);
    chk("ovl_600000", {6'd0, ce}, 8'h02);
    stop(3);

    do_reset();
    cfgin_n = 1'b1;
    start(24'hE80000, 1'b1, 4'h0);
    repeat (6) @(negedge clk);
    chk("cfgin_oe", {7'd0, config_oe}, 8'd0);
    chk("cfgin_dtack", {7'd0, dtack}, 8'd0);
    stop(3);
    cfgin_n = 1'b0;

    for (int t = 0; t < 500; t++) begin
      if (m_cur == N && ($urandom % 3) == 0) do_reset();
      cfgin_n = (($urandom % 10) == 0);
      case ($urandom % 4)
        0, 1:    a = {8'hE8, 9'd0, al_list[$urandom % 16], 1'b0};
        2:       a = {8'($urandom), 9'd0, 6'($urandom), 1'b0};
        default: a = {3'($urandom), 5'd0, 16'd0};
      endcase
      bus(a, 1'($urandom), 4'($urandom), 1 + int'($urandom % 10), 1 + int'($urandom % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
